// File: rtl/conv_window_gen_if.sv
// Stream-in / window-out bundle for conv_window_gen.
// The slave modport is the window generator; the master is the pixel source and MAC-side sink.
interface conv_window_gen_if #(
    parameter int unsigned XS = 32,
    parameter int unsigned WS = 5,
    parameter int unsigned DW = 8
);
    localparam int unsigned AW = (XS > 1) ? $clog2(XS) : 1;

    logic                  iValid;
    logic [DW-1:0]         iData;
    logic                  oValid;
    logic [WS*WS*DW-1:0]   oWindow;
    logic [AW-1:0]         oRow;
    logic [AW-1:0]         oCol;
    logic                  oFrameDone;

    modport master (
        output iValid, iData,
        input  oValid, oWindow, oRow, oCol, oFrameDone
    );

    modport slave (
        input  iValid, iData,
        output oValid, oWindow, oRow, oCol, oFrameDone
    );
endinterface

// File: rtl/conv_window_gen.sv
// Sliding WS x WS window generator over a raster XS x XS pixel stream.
// Keeps WS-1 line buffers and emits one registered window per legal stride position.
module conv_window_gen #(
    parameter int unsigned XS     = 32,
    parameter int unsigned WS     = 5,
    parameter int unsigned STRIDE = 1,
    parameter int unsigned DW     = 8
) (
    input logic              iCLK,
    input logic              iRSTn,
    conv_window_gen_if.slave bus
);
    localparam int unsigned AW = (XS > 1) ? $clog2(XS) : 1;
    localparam int unsigned PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int unsigned WW = WS * WS * DW;

    logic [AW-1:0] col_q, col_d, row_q, row_d;
    logic [AW-1:0] ocol_q, ocol_d, orow_q, orow_d;
    logic [PW-1:0] cph_q, cph_d, rph_q, rph_d;
    logic [WW-1:0] win_q, win_d, out_win_q, out_win_d;
    logic [AW-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
    logic          out_valid_q, out_valid_d, frame_done_q, frame_done_d;

    logic [DW-1:0] lb_mem [WS-1][XS];
    logic [DW-1:0] lb_rd  [WS-1];

    logic col_last, row_last, col_ok, row_ok, fire;

    always_comb begin
        for (int k = 0; k < int'(WS) - 1; k++) begin
            lb_rd[k] = lb_mem[k][col_q];
        end
    end

    // Read-before-write chain: each buffer passes its old pixel one line further down.
    always_ff @(posedge iCLK) begin
        if (bus.iValid) begin
            lb_mem[0][col_q] <= bus.iData;
            for (int k = 1; k < int'(WS) - 1; k++) begin
                lb_mem[k][col_q] <= lb_rd[k-1];
            end
        end
    end

    always_comb begin
        col_last = (col_q == AW'(XS - 1));
        row_last = (row_q == AW'(XS - 1));
        col_ok   = (col_q >= AW'(WS - 1)) && ((STRIDE == 1) || (cph_q == '0));
        row_ok   = (row_q >= AW'(WS - 1)) && ((STRIDE == 1) || (rph_q == '0));
        fire     = bus.iValid && col_ok && row_ok;

        col_d        = col_q;
        row_d        = row_q;
        cph_d        = cph_q;
        rph_d        = rph_q;
        ocol_d       = ocol_q;
        orow_d       = orow_q;
        win_d        = win_q;
        out_win_d    = out_win_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        out_valid_d  = fire;
        frame_done_d = bus.iValid && col_last && row_last;

        if (bus.iValid) begin
            // Column phase/index restart every line; they only advance once col reaches WS-1.
            if (col_last) begin
                col_d  = '0;
                cph_d  = '0;
                ocol_d = '0;
            end else begin
                col_d = col_q + 1'b1;
                if (col_q >= AW'(WS - 1)) begin
                    if (cph_q == PW'(STRIDE - 1)) begin
                        cph_d  = '0;
                        ocol_d = ocol_q + 1'b1;
                    end else begin
                        cph_d = cph_q + 1'b1;
                    end
                end
            end

            if (col_last) begin
                if (row_last) begin
                    row_d  = '0;
                    rph_d  = '0;
                    orow_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                    if (row_q >= AW'(WS - 1)) begin
                        if (rph_q == PW'(STRIDE - 1)) begin
                            rph_d  = '0;
                            orow_d = orow_q + 1'b1;
                        end else begin
                            rph_d = rph_q + 1'b1;
                        end
                    end
                end
            end

            for (int r = 0; r < int'(WS); r++) begin
                for (int c = 0; c < int'(WS) - 1; c++) begin
                    win_d[(r*WS+c)*DW +: DW] = win_q[(r*WS+c+1)*DW +: DW];
                end
                if (r == int'(WS) - 1) begin
                    win_d[(r*WS+WS-1)*DW +: DW] = bus.iData;
                end else begin
                    win_d[(r*WS+WS-1)*DW +: DW] = lb_rd[int'(WS)-2-r];
                end
            end
        end

        if (fire) begin
            out_win_d = win_d;
            out_row_d = orow_q;
            out_col_d = ocol_q;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            col_q        <= '0;
            row_q        <= '0;
            cph_q        <= '0;
            rph_q        <= '0;
            ocol_q       <= '0;
            orow_q       <= '0;
            win_q        <= '0;
            out_win_q    <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            cph_q        <= cph_d;
            rph_q        <= rph_d;
            ocol_q       <= ocol_d;
            orow_q       <= orow_d;
            win_q        <= win_d;
            out_win_q    <= out_win_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.oValid     = out_valid_q;
    assign bus.oWindow    = out_win_q;
    assign bus.oRow       = out_row_q;
    assign bus.oCol       = out_col_q;
    assign bus.oFrameDone = frame_done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: three configurations, windows compared against
// a reference computed directly from the frame image held in the bench.
module tb_conv_window_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_window_gen_if #(.XS(32), .WS(5), .DW(8)) if0 ();
    conv_window_gen_if #(.XS(32), .WS(5), .DW(8)) if1 ();
    conv_window_gen_if #(.XS(8),  .WS(3), .DW(8)) if2 ();

    conv_window_gen #(.XS(32), .WS(5), .STRIDE(1), .DW(8)) u_dut0 (
        .iCLK(clk), .iRSTn(rst_n), .bus(if0.slave));
    conv_window_gen #(.XS(32), .WS(5), .STRIDE(2), .DW(8)) u_dut1 (
        .iCLK(clk), .iRSTn(rst_n), .bus(if1.slave));
    conv_window_gen #(.XS(8),  .WS(3), .STRIDE(1), .DW(8)) u_dut2 (
        .iCLK(clk), .iRSTn(rst_n), .bus(if2.slave));

    int total = 0;
    int bad = 0;
    int img [32][32];

    int           n_win, n_fd, n_badcol, fd_total, last_row, last_col, s2_tl;
    bit           have_first;
    logic         last_fd;
    logic [199:0] first_win;

    function automatic int cfg_xs(input int d); return (d == 2) ? 8 : 32; endfunction
    function automatic int cfg_ws(input int d); return (d == 2) ? 3 : 5;  endfunction
    function automatic int cfg_s(input int d);  return (d == 1) ? 2 : 1;  endfunction

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle on DUT 'dut': optional beat at pixel (r,c), then sample after the edge.
    task automatic beat(input int dut, input bit v, input int r, input int c);
        int xs, ws, s, gr, gc;
        logic gv, gfd;
        logic [199:0] gw, ew;
        bit q;
        xs = cfg_xs(dut);
        ws = cfg_ws(dut);
        s  = cfg_s(dut);
        if0.iValid = (dut == 0) && v;
        if1.iValid = (dut == 1) && v;
        if2.iValid = (dut == 2) && v;
        if0.iData  = 8'(img[r][c]);
        if1.iData  = 8'(img[r][c]);
        if2.iData  = 8'(img[r][c]);
        @(posedge clk);
        #1;
        case (dut)
            0: begin gv = if0.oValid; gfd = if0.oFrameDone; gw = 200'(if0.oWindow);
                     gr = int'(if0.oRow); gc = int'(if0.oCol); end
            1: begin gv = if1.oValid; gfd = if1.oFrameDone; gw = 200'(if1.oWindow);
                     gr = int'(if1.oRow); gc = int'(if1.oCol); end
            default: begin gv = if2.oValid; gfd = if2.oFrameDone; gw = 200'(if2.oWindow);
                     gr = int'(if2.oRow); gc = int'(if2.oCol); end
        endcase
        q = v && (r >= ws - 1) && (c >= ws - 1)
            && ((r - ws + 1) % s == 0) && ((c - ws + 1) % s == 0);
        check("valid", 200'(gv), 200'(q));
        check("frame_done", 200'(gfd), 200'(v && (r == xs - 1) && (c == xs - 1)));
        if (q) begin
            ew = '0;
            for (int rr = 0; rr < ws; rr++) begin
                for (int cc = 0; cc < ws; cc++) begin
                    ew[(rr*ws+cc)*8 +: 8] = 8'(img[r-ws+1+rr][c-ws+1+cc]);
                end
            end
            check("window", gw, ew);
            check("row_idx", 200'(gr), 200'((r - ws + 1) / s));
            check("col_idx", 200'(gc), 200'((c - ws + 1) / s));
        end
        if (gv === 1'b1) begin
            n_win++;
            if (!have_first) begin
                first_win  = gw;
                have_first = 1'b1;
            end
            last_row = gr;
            last_col = gc;
            last_fd  = gfd;
            if (gr == 1 && gc == 1) s2_tl = int'(gw[7:0]);
            if (v && c < ws - 1) n_badcol++;
        end
        if (gfd === 1'b1) begin
            n_fd++;
            fd_total++;
        end
    endtask

    task automatic frame(input int dut, input int base, input bit gaps, input int npix);
        int xs;
        xs = cfg_xs(dut);
        for (int r = 0; r < xs; r++) begin
            for (int c = 0; c < xs; c++) begin
                img[r][c] = (r * xs + c + base) % 256;
            end
        end
        n_win      = 0;
        n_fd       = 0;
        n_badcol   = 0;
        have_first = 1'b0;
        for (int p = 0; p < npix; p++) begin
            if (gaps) begin
                while ($urandom_range(1) == 0) beat(dut, 1'b0, 0, 0);
            end
            beat(dut, 1'b1, p / xs, p % xs);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 200'(if0.oValid), 200'(0));
        check({tag, "_window"}, 200'(if0.oWindow), 200'(0));
        check({tag, "_row"}, 200'(if0.oRow), 200'(0));
        check({tag, "_col"}, 200'(if0.oCol), 200'(0));
        check({tag, "_fd"}, 200'(if0.oFrameDone), 200'(0));
    endtask

    initial begin
        if0.iValid = 1'b0; if0.iData = '0;
        if1.iValid = 1'b0; if1.iData = '0;
        if2.iValid = 1'b0; if2.iData = '0;
        fd_total = 0;
        s2_tl    = -1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;

        // Continuous ramp frame.
        frame(0, 0, 1'b0, 1024);
        check("ramp_count", 200'(n_win), 200'(784));
        check("ramp_fd_count", 200'(n_fd), 200'(1));
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                check("ramp_first_elem", 200'(first_win[(r*5+c)*8 +: 8]), 200'(r * 32 + c));
            end
        end
        check("ramp_last_row", 200'(last_row), 200'(27));
        check("ramp_last_col", 200'(last_col), 200'(27));
        check("ramp_last_fd", 200'(last_fd), 200'(1));

        // Same ramp with random idle cycles.
        frame(0, 0, 1'b1, 1024);
        check("gap_count", 200'(n_win), 200'(784));
        check("gap_fd_count", 200'(n_fd), 200'(1));

        // Stride 2.
        frame(1, 0, 1'b0, 1024);
        check("s2_count", 200'(n_win), 200'(196));
        check("s2_last_row", 200'(last_row), 200'(13));
        check("s2_last_col", 200'(last_col), 200'(13));
        check("s2_top_left_1_1", 200'(s2_tl), 200'(66));

        // Back-to-back frames, second one offset by 100.
        fd_total = 0;
        frame(0, 0, 1'b0, 1024);
        check("b2b_f1_count", 200'(n_win), 200'(784));
        frame(0, 100, 1'b0, 1024);
        check("b2b_f2_count", 200'(n_win), 200'(784));
        check("b2b_f2_first_elem", 200'(first_win[7:0]), 200'(100));
        check("b2b_fd_total", 200'(fd_total), 200'(2));

        // Reset in the middle of a frame, then a clean frame.
        frame(0, 0, 1'b0, 200);
        if0.iValid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        #2 rst_n = 1'b1;
        frame(0, 0, 1'b0, 1024);
        check("post_rst_count", 200'(n_win), 200'(784));
        check("post_rst_fd", 200'(n_fd), 200'(1));

        // Small image: XS=8, WS=3.
        frame(2, 0, 1'b0, 64);
        check("small_count", 200'(n_win), 200'(36));
        check("small_col_boundary", 200'(n_badcol), 200'(0));
        check("small_last_row", 200'(last_row), 200'(5));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
